// File: rtl/rgb2hsv_pipe_if.sv
// rgb2hsv_pipe_if
// Pixel stream bundle for the RGB-to-HSV converter.
//   ce        : pipeline clock enable (driven by the stream source)
//   in_valid  : input pixel qualifier
//   in_rgb    : {R, G, B}, R in the MSBs, DW bits per component
//   in_sb     : sideband bits aligned to in_rgb
//   out_valid : output qualifier
//   out_h     : hue (half-degrees or degrees, 9 bits)
//   out_s     : saturation, DW bits
//   out_v     : value, DW bits
//   out_sb    : in_sb delayed to match the pixel
// master = pixel source / sink side, slave = converter side.
interface rgb2hsv_pipe_if #(
    parameter int DW  = 8,
    parameter int SBW = 3
);
    logic            ce;
    logic            in_valid;
    logic [3*DW-1:0] in_rgb;
    logic [SBW-1:0]  in_sb;
    logic            out_valid;
    logic [8:0]      out_h;
    logic [DW-1:0]   out_s;
    logic [DW-1:0]   out_v;
    logic [SBW-1:0]  out_sb;

    modport master (
        output ce, in_valid, in_rgb, in_sb,
        input  out_valid, out_h, out_s, out_v, out_sb
    );

    modport slave (
        input  ce, in_valid, in_rgb, in_sb,
        output out_valid, out_h, out_s, out_v, out_sb
    );
endinterface

// File: rtl/rgb2hsv_pipe.sv
// rgb2hsv_pipe
// Fully pipelined RGB-to-HSV converter, one pixel per enabled clock.
// Latency is DW+4 enabled cycles: input register, max/min/delta,
// dividend/divisor/base setup, DW restoring-divider stages (one quotient
// bit each, S and H lanes in parallel), hue combine + output register.
// Ports:
//   pclk : pixel clock, rising edge
//   rst  : synchronous active-high reset; clears valid chain and outputs
//   bus  : rgb2hsv_pipe_if slave (ce, in_*, out_*)
// Parameters: DW component width (6..12), SBW sideband width,
//   HUE_MODE 0 = half-degrees (0..179), 1 = degrees (0..359).
module rgb2hsv_pipe #(
    parameter int DW       = 8,
    parameter int SBW      = 3,
    parameter int HUE_MODE = 0
) (
    input logic           pclk,
    input logic           rst,
    rgb2hsv_pipe_if.slave bus
);
    // Dividend width covers M*delta (< 2^(2*DW)) and 60*d with headroom.
    localparam int            XW   = 2 * DW + 6;
    localparam logic [XW-1:0] MAXC = XW'((1 << DW) - 1);

    function automatic logic [DW-1:0] max3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        logic [DW-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [DW-1:0] min3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        logic [DW-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    // One restoring step: subtract den<<sh if it fits, shift the bit into q.
    function automatic logic [XW+DW-1:0] div_step(input logic [XW-1:0] rem,
                                                  input logic [DW-1:0] den,
                                                  input logic [DW-1:0] q,
                                                  input int            sh);
        logic [XW-1:0] trial;
        trial = XW'(den) << sh;
        if (rem >= trial) return {rem - trial, q[DW-2:0], 1'b1};
        else              return {rem, q[DW-2:0], 1'b0};
    endfunction

    // 360 - 0 arises when the wrap-side difference is tiny; fold it to 0.
    function automatic logic [8:0] hue_deg(input logic [8:0] base, input logic neg,
                                           input logic [8:0] q);
        logic [8:0] t;
        t = neg ? (base - q) : (base + q);
        return (t >= 9'd360) ? (t - 9'd360) : t;
    endfunction

    // Stage p0: input register
    logic [DW-1:0]  r_p0, g_p0, b_p0;
    logic [SBW-1:0] sb_p0;
    logic           vld_p0;

    always_ff @(posedge pclk) begin
        if (rst)         vld_p0 <= 1'b0;
        else if (bus.ce) vld_p0 <= bus.in_valid;
    end

    always_ff @(posedge pclk) begin
        if (bus.ce) begin
            {r_p0, g_p0, b_p0} <= bus.in_rgb;
            sb_p0              <= bus.in_sb;
        end
    end

    // Stage p1: max / min / delta
    logic [DW-1:0]  r_p1, g_p1, b_p1, mx_p1, dl_p1;
    logic [SBW-1:0] sb_p1;
    logic           vld_p1;

    always_ff @(posedge pclk) begin
        if (rst)         vld_p1 <= 1'b0;
        else if (bus.ce) vld_p1 <= vld_p0;
    end

    always_ff @(posedge pclk) begin
        if (bus.ce) begin
            r_p1  <= r_p0;
            g_p1  <= g_p0;
            b_p1  <= b_p0;
            mx_p1 <= max3(r_p0, g_p0, b_p0);
            dl_p1 <= max3(r_p0, g_p0, b_p0) - min3(r_p0, g_p0, b_p0);
            sb_p1 <= sb_p0;
        end
    end

    // Stage p2: hue base/sign select, dividend/divisor setup
    logic [8:0]    base_c;
    logic          neg_c;
    logic [DW-1:0] d_c;

    always_comb begin
        base_c = 9'd0;
        neg_c  = 1'b0;
        d_c    = '0;
        if (dl_p1 != '0) begin
            if (mx_p1 == r_p1) begin
                if (g_p1 >= b_p1) begin
                    d_c = g_p1 - b_p1;
                end else begin
                    base_c = 9'd360;
                    neg_c  = 1'b1;
                    d_c    = b_p1 - g_p1;
                end
            end else if (mx_p1 == g_p1) begin
                base_c = 9'd120;
                if (b_p1 >= r_p1) begin
                    d_c = b_p1 - r_p1;
                end else begin
                    neg_c = 1'b1;
                    d_c   = r_p1 - b_p1;
                end
            end else begin
                base_c = 9'd240;
                if (r_p1 >= g_p1) begin
                    d_c = r_p1 - g_p1;
                end else begin
                    neg_c = 1'b1;
                    d_c   = g_p1 - r_p1;
                end
            end
        end
    end

    logic [XW-1:0]  s_num_p2, h_num_p2;
    logic [DW-1:0]  s_den_p2, h_den_p2, v_p2;
    logic [8:0]     base_p2;
    logic           neg_p2;
    logic [SBW-1:0] sb_p2;
    logic           vld_p2;

    always_ff @(posedge pclk) begin
        if (rst)         vld_p2 <= 1'b0;
        else if (bus.ce) vld_p2 <= vld_p1;
    end

    // A zero divisor becomes 1 with a zero dividend, so the quotient is 0.
    always_ff @(posedge pclk) begin
        if (bus.ce) begin
            s_num_p2 <= (mx_p1 == '0) ? '0 : XW'(dl_p1) * MAXC;
            s_den_p2 <= (mx_p1 == '0) ? DW'(1) : mx_p1;
            h_num_p2 <= (dl_p1 == '0) ? '0 : XW'(d_c) * XW'(60);
            h_den_p2 <= (dl_p1 == '0) ? DW'(1) : dl_p1;
            base_p2  <= base_c;
            neg_p2   <= neg_c;
            v_p2     <= mx_p1;
            sb_p2    <= sb_p1;
        end
    end

    // Stages pd[0..DW-1]: restoring divider, quotient bit DW-1-k at stage k
    for (genvar k = 0; k < DW; k++) begin : g_div
        logic [XW-1:0]  s_rem_in, h_rem_in, s_rem_pd, h_rem_pd;
        logic [DW-1:0]  s_den_in, h_den_in, s_q_in, h_q_in, v_in;
        logic [DW-1:0]  s_den_pd, h_den_pd, s_q_pd, h_q_pd, v_pd;
        logic [8:0]     base_in, base_pd;
        logic           neg_in, neg_pd, vld_in, vld_pd;
        logic [SBW-1:0] sb_in, sb_pd;

        if (k == 0) begin : g_first
            assign s_rem_in = s_num_p2;
            assign h_rem_in = h_num_p2;
            assign s_den_in = s_den_p2;
            assign h_den_in = h_den_p2;
            assign s_q_in   = '0;
            assign h_q_in   = '0;
            assign v_in     = v_p2;
            assign base_in  = base_p2;
            assign neg_in   = neg_p2;
            assign vld_in   = vld_p2;
            assign sb_in    = sb_p2;
        end else begin : g_next
            assign s_rem_in = g_div[k-1].s_rem_pd;
            assign h_rem_in = g_div[k-1].h_rem_pd;
            assign s_den_in = g_div[k-1].s_den_pd;
            assign h_den_in = g_div[k-1].h_den_pd;
            assign s_q_in   = g_div[k-1].s_q_pd;
            assign h_q_in   = g_div[k-1].h_q_pd;
            assign v_in     = g_div[k-1].v_pd;
            assign base_in  = g_div[k-1].base_pd;
            assign neg_in   = g_div[k-1].neg_pd;
            assign vld_in   = g_div[k-1].vld_pd;
            assign sb_in    = g_div[k-1].sb_pd;
        end

        always_ff @(posedge pclk) begin
            if (rst)         vld_pd <= 1'b0;
            else if (bus.ce) vld_pd <= vld_in;
        end

        always_ff @(posedge pclk) begin
            if (bus.ce) begin
                {s_rem_pd, s_q_pd} <= div_step(s_rem_in, s_den_in, s_q_in, DW - 1 - k);
                {h_rem_pd, h_q_pd} <= div_step(h_rem_in, h_den_in, h_q_in, DW - 1 - k);
                s_den_pd           <= s_den_in;
                h_den_pd           <= h_den_in;
                v_pd               <= v_in;
                base_pd            <= base_in;
                neg_pd             <= neg_in;
                sb_pd              <= sb_in;
            end
        end
    end

    // Stage p3: hue combine + output register
    logic [8:0] deg_c;
    logic [8:0] hue_c;

    always_comb begin
        deg_c = hue_deg(g_div[DW-1].base_pd, g_div[DW-1].neg_pd, 9'(g_div[DW-1].h_q_pd));
        hue_c = (HUE_MODE != 0) ? deg_c : {1'b0, deg_c[8:1]};
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_h     <= '0;
            bus.out_s     <= '0;
            bus.out_v     <= '0;
            bus.out_sb    <= '0;
        end else if (bus.ce) begin
            bus.out_valid <= g_div[DW-1].vld_pd;
            bus.out_h     <= hue_c;
            bus.out_s     <= g_div[DW-1].s_q_pd;
            bus.out_v     <= g_div[DW-1].v_pd;
            bus.out_sb    <= g_div[DW-1].sb_pd;
        end
    end
endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// tb_rgb2hsv_pipe
// Drives three converters in lockstep (DW=8 half-degree, DW=8 degree,
// DW=10 degree) from one directed stimulus sequence. Expected results are
// queued when a pixel is sampled and popped when out_valid appears.
module tb_rgb2hsv_pipe;
    localparam int L8  = 12;
    localparam int L10 = 14;

    typedef struct {
        logic [8:0]  h;
        logic [11:0] s;
        logic [11:0] v;
        logic [2:0]  sb;
        int          at;
    } exp_t;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    always #5 pclk = ~pclk;

    rgb2hsv_pipe_if #(.DW(8),  .SBW(3)) if0 ();
    rgb2hsv_pipe_if #(.DW(8),  .SBW(3)) if1 ();
    rgb2hsv_pipe_if #(.DW(10), .SBW(3)) if2 ();

    rgb2hsv_pipe #(.DW(8),  .SBW(3), .HUE_MODE(0)) u0 (.pclk(pclk), .rst(rst), .bus(if0));
    rgb2hsv_pipe #(.DW(8),  .SBW(3), .HUE_MODE(1)) u1 (.pclk(pclk), .rst(rst), .bus(if1));
    rgb2hsv_pipe #(.DW(10), .SBW(3), .HUE_MODE(1)) u2 (.pclk(pclk), .rst(rst), .bus(if2));

    exp_t q0[$], q1[$], q2[$];
    exp_t nx0, nx1, nx2, tmp_e;
    int   checks = 0;
    int   errors = 0;
    int   en_cnt = 0;
    logic rst_seen = 1'b1;
    logic ce_seen  = 1'b1;

    logic        pvld [3];
    logic [8:0]  ph   [3];
    logic [11:0] ps   [3];
    logic [11:0] pv   [3];
    logic [2:0]  psb  [3];

    function automatic exp_t model(input int r, input int g, input int b, input int dw,
                                   input int mode);
        exp_t e;
        int mx, mn, dl, deg;
        mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
        mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
        dl = mx - mn;
        e.s = 12'((mx == 0) ? 0 : (((1 << dw) - 1) * dl) / mx);
        if (dl == 0)      deg = 0;
        else if (mx == r) deg = (g >= b) ? (60 * (g - b)) / dl : 360 - (60 * (b - g)) / dl;
        else if (mx == g) deg = (b >= r) ? 120 + (60 * (b - r)) / dl : 120 - (60 * (r - b)) / dl;
        else              deg = (r >= g) ? 240 + (60 * (r - g)) / dl : 240 - (60 * (g - r)) / dl;
        if (deg >= 360) deg = deg - 360;
        e.h  = 9'((mode != 0) ? deg : deg / 2);
        e.v  = 12'(mx);
        e.sb = 3'd0;
        e.at = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Record what each converter samples on this edge.
    always @(posedge pclk) begin
        rst_seen <= rst;
        ce_seen  <= if0.ce;
        if (rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else if (if0.ce) begin
            en_cnt <= en_cnt + 1;
            if (if0.in_valid) begin
                tmp_e = nx0; tmp_e.at = en_cnt + 1; q0.push_back(tmp_e);
                tmp_e = nx1; tmp_e.at = en_cnt + 1; q1.push_back(tmp_e);
                tmp_e = nx2; tmp_e.at = en_cnt + 1; q2.push_back(tmp_e);
            end
        end
    end

    task automatic check_port(input int p, input logic vld, input logic [8:0] h,
                              input logic [11:0] s, input logic [11:0] v,
                              input logic [2:0] sb, input int lat);
        exp_t  e;
        int    n;
        string tg;
        tg = $sformatf("u%0d", p);
        n  = 0;
        case (p)
            0:       begin n = q0.size(); if (n > 0) e = q0[0]; end
            1:       begin n = q1.size(); if (n > 0) e = q1[0]; end
            default: begin n = q2.size(); if (n > 0) e = q2[0]; end
        endcase
        if (rst_seen) begin
            chk({tg, "_rst_valid"}, 32'(vld), 0);
            chk({tg, "_rst_h"},     32'(h),   0);
            chk({tg, "_rst_s"},     32'(s),   0);
            chk({tg, "_rst_v"},     32'(v),   0);
            chk({tg, "_rst_sb"},    32'(sb),  0);
        end else if (!ce_seen) begin
            chk({tg, "_hold_valid"}, 32'(vld), 32'(pvld[p]));
            chk({tg, "_hold_h"},     32'(h),   32'(ph[p]));
            chk({tg, "_hold_s"},     32'(s),   32'(ps[p]));
            chk({tg, "_hold_v"},     32'(v),   32'(pv[p]));
            chk({tg, "_hold_sb"},    32'(sb),  32'(psb[p]));
        end else if (vld) begin
            if (n == 0) begin
                chk({tg, "_unexpected_valid"}, 32'(vld), 0);
            end else begin
                case (p)
                    0:       e = q0.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                chk({tg, "_h"},       32'(h),  32'(e.h));
                chk({tg, "_s"},       32'(s),  32'(e.s));
                chk({tg, "_v"},       32'(v),  32'(e.v));
                chk({tg, "_sb"},      32'(sb), 32'(e.sb));
                chk({tg, "_latency"}, 32'(en_cnt - e.at + 1), 32'(lat));
            end
        end else if (n > 0 && (en_cnt - e.at + 1) >= lat) begin
            chk({tg, "_late_valid"}, 32'(vld), 1);
        end
        pvld[p] = vld;
        ph[p]   = h;
        ps[p]   = s;
        pv[p]   = v;
        psb[p]  = sb;
    endtask

    always @(negedge pclk) begin
        check_port(0, if0.out_valid, if0.out_h, 12'(if0.out_s), 12'(if0.out_v), if0.out_sb, L8);
        check_port(1, if1.out_valid, if1.out_h, 12'(if1.out_s), 12'(if1.out_v), if1.out_sb, L8);
        check_port(2, if2.out_valid, if2.out_h, 12'(if2.out_s), 12'(if2.out_v), if2.out_sb, L10);
    end

    // Present one slot to all three converters and advance one clock.
    task automatic drive(input logic vld, input logic c, input int r, input int g, input int b,
                         input int eh0, input int eh1, input int es, input int ev);
        logic [2:0] sb;
        int r2, g2, b2;
        sb = 3'($urandom_range(0, 7));
        r2 = $urandom_range(0, 1023);
        g2 = $urandom_range(0, 1023);
        b2 = $urandom_range(0, 1023);
        if0.ce = c; if1.ce = c; if2.ce = c;
        if0.in_valid = vld; if1.in_valid = vld; if2.in_valid = vld;
        if0.in_rgb = {8'(r), 8'(g), 8'(b)};
        if1.in_rgb = {8'(r), 8'(g), 8'(b)};
        if2.in_rgb = {10'(r2), 10'(g2), 10'(b2)};
        if0.in_sb = sb; if1.in_sb = sb; if2.in_sb = ~sb;
        nx0.h = 9'(eh0); nx0.s = 12'(es); nx0.v = 12'(ev); nx0.sb = sb; nx0.at = 0;
        nx1.h = 9'(eh1); nx1.s = 12'(es); nx1.v = 12'(ev); nx1.sb = sb; nx1.at = 0;
        nx2 = model(r2, g2, b2, 10, 1);
        nx2.sb = ~sb;
        @(posedge pclk);
        #1;
    endtask

    task automatic px(input int r, input int g, input int b, input int h0, input int h1,
                      input int s, input int v);
        drive(1'b1, 1'b1, r, g, b, h0, h1, s, v);
    endtask

    task automatic rnd(input logic vld, input logic c);
        exp_t m0, m1;
        int r, g, b;
        r = $urandom_range(0, 255);
        g = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        m0 = model(r, g, b, 8, 0);
        m1 = model(r, g, b, 8, 1);
        drive(vld, c, r, g, b, int'(m0.h), int'(m1.h), int'(m0.s), int'(m0.v));
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        logic c;
        if0.ce = 1'b1; if1.ce = 1'b1; if2.ce = 1'b1;
        if0.in_valid = 1'b0; if1.in_valid = 1'b0; if2.in_valid = 1'b0;
        if0.in_rgb = '0; if1.in_rgb = '0; if2.in_rgb = '0;
        if0.in_sb = '0; if1.in_sb = '0; if2.in_sb = '0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;

        // Primaries, grey levels, mixed, wrap and tie cases, back-to-back.
        px(255,   0,   0,   0,   0, 255, 255);
        px(  0, 255,   0,  60, 120, 255, 255);
        px(  0,   0, 255, 120, 240, 255, 255);
        px(128, 128, 128,   0,   0,   0, 128);
        px(  0,   0,   0,   0,   0,   0,   0);
        px(255, 255, 255,   0,   0,   0, 255);
        px(200, 100,  50,  10,  20, 191, 200);
        px(255,   0, 128, 165, 330, 255, 255);
        px(  0, 128, 255, 105, 210, 255, 255);
        px(255, 255,   0,  30,  60, 255, 255);
        px(255,   0, 255, 150, 300, 255, 255);
        px(  0, 255, 255,  90, 180, 255, 255);
        px(255,   0,   1,   0,   0, 255, 255);
        idle(L10 + 2);

        // Random stream with pseudo-random clock enable.
        n = 0;
        while (n < 20) begin
            c = ($urandom_range(0, 2) != 0);
            rnd(1'b1, c);
            if (c) n++;
        end
        repeat (30) rnd(1'b0, 1'($urandom_range(0, 1)));
        idle(L10 + 2);

        // Reset with five pixels in flight, then one pixel afterwards.
        repeat (5) rnd(1'b1, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rnd(1'b1, 1'b1);
        idle(L10 + 2);

        // Reset wins over a deasserted clock enable.
        repeat (3) rnd(1'b1, 1'b1);
        rst = 1'b1;
        rnd(1'b0, 1'b0);
        rst = 1'b0;
        repeat (4) rnd(1'b1, 1'b1);
        idle(L10 + 2);

        chk("u0_drain", 32'(q0.size()), 0);
        chk("u1_drain", 32'(q1.size()), 0);
        chk("u2_drain", 32'(q2.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
